// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing a falling-edge 128x32 SRAM between the core and a loader/debug port.
// Same-cycle grants, registered read return, and a saturating contention counter.
module dmem_arbiter #(
    parameter int AW       = 7,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          c_gnt,
    output logic          l_gnt,
    output logic          c_rvalid,
    output logic          l_rvalid,
    output logic [DW-1:0] c_rdata,
    output logic [DW-1:0] l_rdata,
    output logic          mem_cen,
    output logic          mem_wen,
    output logic          mem_oen,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_q,
    output logic [15:0]   conflict_cnt
);

    logic       last_gnt;
    logic [3:0] l_wait;
    logic       rd_pend;
    logic       rd_owner;
    logic       cr, lr, pick_l, rd_gnt;

    // Requests are masked while reset is held so grants and SRAM controls go idle immediately.
    always_comb begin
        cr = c_req & ~rst;
        lr = l_req & ~rst;
        if (mode)
            pick_l = ~last_gnt;
        else
            pick_l = (l_wait == 4'(MAX_WAIT));
        l_gnt  = lr & (~cr | pick_l);
        c_gnt  = cr & ~l_gnt;
        rd_gnt = (c_gnt & ~c_we) | (l_gnt & ~l_we);
    end

    always_comb begin
        mem_cen = 1'b1;
        mem_wen = 1'b1;
        mem_oen = 1'b1;
        mem_a   = '0;
        mem_d   = '0;
        if (c_gnt) begin
            mem_cen = 1'b0;
            mem_wen = ~c_we;
            mem_oen = c_we;
            mem_a   = c_addr;
            mem_d   = c_wdata;
        end else if (l_gnt) begin
            mem_cen = 1'b0;
            mem_wen = ~l_we;
            mem_oen = l_we;
            mem_a   = l_addr;
            mem_d   = l_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt     <= 1'b1;
            l_wait       <= '0;
            rd_pend      <= 1'b0;
            rd_owner     <= 1'b0;
            c_rdata      <= '0;
            l_rdata      <= '0;
            conflict_cnt <= '0;
        end else begin
            if (c_gnt || l_gnt)
                last_gnt <= l_gnt;

            if (lr && !l_gnt)
                l_wait <= (l_wait == 4'(MAX_WAIT)) ? l_wait : l_wait + 4'd1;
            else
                l_wait <= '0;

            if (cr && lr && conflict_cnt != '1)
                conflict_cnt <= conflict_cnt + 16'd1;

            // The SRAM presented its data on the falling edge of the grant cycle.
            rd_pend <= rd_gnt;
            if (rd_gnt) begin
                rd_owner <= l_gnt;
                if (l_gnt)
                    l_rdata <= mem_q;
                else
                    c_rdata <= mem_q;
            end
        end
    end

    assign c_rvalid = rd_pend & ~rd_owner;
    assign l_rvalid = rd_pend & rd_owner;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural falling-edge SRAM model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        c_req, c_we, l_req, l_we;
    logic [6:0]  c_addr, l_addr;
    logic [31:0] c_wdata, l_wdata;
    logic        c_gnt, l_gnt, c_rvalid, l_rvalid;
    logic [31:0] c_rdata, l_rdata;
    logic        mem_cen, mem_wen, mem_oen;
    logic [6:0]  mem_a;
    logic [31:0] mem_d, mem_q;
    logic [15:0] conflict_cnt;

    int passed = 0;
    int total  = 0;

    dmem_arbiter #(.AW(7), .DW(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .c_gnt(c_gnt), .l_gnt(l_gnt), .c_rvalid(c_rvalid), .l_rvalid(l_rvalid),
        .c_rdata(c_rdata), .l_rdata(l_rdata),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_oen(mem_oen),
        .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0] sram [128];
    initial mem_q = '0;
    always @(negedge clk) begin
        if (!mem_cen) begin
            if (!mem_wen)
                sram[mem_a] <= mem_d;
            else if (!mem_oen)
                mem_q <= sram[mem_a];
        end
    end

    logic mon_en = 1'b0;
    int   both_gnt = 0;
    int   l_grants = 0;
    always @(negedge clk) begin
        if (c_gnt && l_gnt) both_gnt++;
        if (mon_en && l_gnt) l_grants++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    typedef struct {
        logic        md;
        logic        cr, cw;
        logic [6:0]  ca;
        logic [31:0] cd;
        logic        lr, lw;
        logic [6:0]  la;
        logic [31:0] ld;
        logic        egc, egl, ecv, elv;
        logic [31:0] ecd, eld;
        logic [15:0] ecnt;
        logic [2:0]  emem;
    } vec_t;

    vec_t v [23];

    task automatic drive_idle();
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
    endtask

    initial begin
        // {mode, c req/we/addr/data, l req/we/addr/data, c_gnt, l_gnt, c_rv, l_rv, c_rdata, l_rdata, cnt, {cen,wen,oen}}
        v[0]  = '{0, 0,0,0,0,  1,1,0,15, 0,1,0,0,  0, 0,  0, 3'b001};
        v[1]  = '{0, 0,0,0,0,  1,1,1,20, 0,1,0,0,  0, 0,  0, 3'b001};
        v[2]  = '{0, 0,0,0,0,  1,0,1,0,  0,1,0,0,  0, 0,  0, 3'b010};
        v[3]  = '{0, 1,0,0,0,  0,0,0,0,  1,0,0,1,  0, 20, 0, 3'b010};
        v[4]  = '{0, 1,0,1,0,  0,0,0,0,  1,0,1,0,  15,20, 0, 3'b010};
        v[5]  = '{0, 0,0,0,0,  0,0,0,0,  0,0,1,0,  20,20, 0, 3'b111};
        v[6]  = '{0, 1,0,0,0,  1,0,1,0,  1,0,0,0,  20,20, 0, 3'b010};
        v[7]  = '{0, 1,0,0,0,  1,0,1,0,  1,0,1,0,  15,20, 1, 3'b010};
        v[8]  = '{0, 1,0,0,0,  1,0,1,0,  1,0,1,0,  15,20, 2, 3'b010};
        v[9]  = '{0, 1,0,0,0,  1,0,1,0,  1,0,1,0,  15,20, 3, 3'b010};
        v[10] = '{0, 1,0,0,0,  1,0,1,0,  0,1,1,0,  15,20, 4, 3'b010};
        v[11] = '{0, 1,0,0,0,  1,0,1,0,  1,0,0,1,  15,20, 5, 3'b010};
        v[12] = '{0, 1,0,0,0,  1,0,1,0,  1,0,1,0,  15,20, 6, 3'b010};
        v[13] = '{0, 1,0,0,0,  1,0,1,0,  1,0,1,0,  15,20, 7, 3'b010};
        v[14] = '{0, 1,0,0,0,  1,0,1,0,  1,0,1,0,  15,20, 8, 3'b010};
        v[15] = '{0, 1,0,0,0,  1,0,1,0,  0,1,1,0,  15,20, 9, 3'b010};
        v[16] = '{1, 1,0,0,0,  1,0,1,0,  1,0,0,1,  15,20, 10, 3'b010};
        v[17] = '{1, 1,0,0,0,  1,0,1,0,  0,1,1,0,  15,20, 11, 3'b010};
        v[18] = '{1, 1,0,0,0,  1,0,1,0,  1,0,0,1,  15,20, 12, 3'b010};
        v[19] = '{1, 1,0,0,0,  1,0,1,0,  0,1,1,0,  15,20, 13, 3'b010};
        v[20] = '{1, 1,1,4,30, 1,0,4,0,  1,0,0,1,  15,20, 14, 3'b001};
        v[21] = '{1, 0,0,0,0,  1,0,4,0,  0,1,0,0,  15,20, 15, 3'b010};
        v[22] = '{1, 0,0,0,0,  0,0,0,0,  0,0,0,1,  15,30, 15, 3'b111};

        // Reset with requests asserted: everything must read idle.
        rst = 1; mode = 0; drive_idle();
        c_req = 1; l_req = 1;
        #3;
        chk("rst c_gnt", c_gnt, 0);
        chk("rst l_gnt", l_gnt, 0);
        chk("rst rvalid", {c_rvalid, l_rvalid}, 0);
        chk("rst rdata", c_rdata | l_rdata, 0);
        chk("rst cnt", conflict_cnt, 0);
        chk("rst mem ctl", {mem_cen, mem_wen, mem_oen}, 3'b111);
        chk("rst mem a/d", {mem_a, mem_d}, 0);
        @(posedge clk); #1;
        rst = 0; drive_idle();

        for (int i = 0; i < 23; i++) begin
            mode = v[i].md;
            c_req = v[i].cr; c_we = v[i].cw; c_addr = v[i].ca; c_wdata = v[i].cd;
            l_req = v[i].lr; l_we = v[i].lw; l_addr = v[i].la; l_wdata = v[i].ld;
            #2;
            chk($sformatf("v%0d c_gnt", i), c_gnt, v[i].egc);
            chk($sformatf("v%0d l_gnt", i), l_gnt, v[i].egl);
            chk($sformatf("v%0d c_rvalid", i), c_rvalid, v[i].ecv);
            chk($sformatf("v%0d l_rvalid", i), l_rvalid, v[i].elv);
            chk($sformatf("v%0d c_rdata", i), c_rdata, v[i].ecd);
            chk($sformatf("v%0d l_rdata", i), l_rdata, v[i].eld);
            chk($sformatf("v%0d cnt", i), conflict_cnt, v[i].ecnt);
            chk($sformatf("v%0d mem ctl", i), {mem_cen, mem_wen, mem_oen}, v[i].emem);
            @(posedge clk); #1;
        end
        drive_idle();

        // Reset lands between a core read grant and its rvalid cycle.
        mode = 0; c_req = 1; c_addr = 7'd0;
        #2;
        chk("mid-read grant", c_gnt, 1);
        #4 rst = 1;
        #1;
        chk("mid-read rst c_gnt", c_gnt, 0);
        chk("mid-read rst rdata", c_rdata | l_rdata, 0);
        chk("mid-read rst cnt", conflict_cnt, 0);
        chk("mid-read rst mem_cen", mem_cen, 1);
        @(posedge clk); #1;
        chk("mid-read no rvalid", c_rvalid, 0);
        drive_idle();
        rst = 0;

        // Round-robin from reset: core first, then alternating.
        mode = 1; c_req = 1; c_addr = 7'd0; l_req = 1; l_addr = 7'd1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("rr%0d c_gnt", i), c_gnt, (i % 2 == 0));
            chk($sformatf("rr%0d l_gnt", i), l_gnt, (i % 2 == 1));
            if (i == 1) chk("rr c_rdata", c_rdata, 15);
            if (i == 2) chk("rr l_rdata", l_rdata, 20);
            @(posedge clk); #1;
        end
        drive_idle();

        // Long contention in mode 0: starvation guard cadence and counter saturation.
        rst = 1; #1; rst = 0;
        mode = 0; c_req = 1; c_addr = 7'd0; l_req = 1; l_addr = 7'd1;
        mon_en = 1;
        repeat (65534) @(posedge clk);
        #1;
        mon_en = 0;
        chk("sat cnt 65534", conflict_cnt, 16'd65534);
        chk("guard loader grants", l_grants, 13106);
        repeat (5) @(posedge clk);
        #1;
        chk("sat cnt stops", conflict_cnt, 16'hFFFF);
        chk("never both granted", both_gnt, 0);
        drive_idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
